npc_ctrl: RTL
=============

# npc_ctrl

Multi-cycle sequencer for the RV64I NPC core. It owns the PC and the IF/ID instruction register, and drives the instruction-memory and data-memory handshakes. It steps each instruction through fetch, decode, execute, memory and writeback, and issues register-file write enables to the combinational decode/execute datapath. It also halts the core on `ebreak` or an illegal opcode, and keeps cycle and retired-instruction counters.

## Interface
Parameters:
- `RESET_PC`, default 64'h8000_0000: PC loaded on reset.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  core clock
- `rst`  in  1  synchronous active-high reset
- `imem_req_valid`  out  1  fetch request
- `imem_req_ready`  in  1  imem accepts request
- `imem_addr`  out  64  fetch address (= `pc_o`)
- `imem_rsp_valid`  in  1  fetch data valid
- `imem_rsp_data`  in  32  fetched instruction
- `dmem_req_valid`  out  1  load/store request
- `dmem_req_ready`  in  1  dmem accepts request
- `dmem_rsp_valid`  in  1  load data returned / store completed
- `next_pc_i`  in  64  next PC from execute (pc+4, branch or jump target)
- `pc_o`  out  64  current instruction PC
- `inst_o`  out  32  IF/ID register, feeds the decoder
- `rf_wen`  out  1  register-file write enable, one cycle
- `halt`  out  1  core stopped
- `illegal`  out  1  stop was caused by an illegal instruction
- `cycle_cnt`  out  64  cycles since reset
- `instret_cnt`  out  64  retired instructions

## Operation
- States: `FETCH_REQ`, `FETCH_WAIT`, `DECODE`, `EXECUTE`, `MEM_REQ`, `MEM_WAIT`, `WRITEBACK`, `HALT`.
- `FETCH_REQ`: `imem_req_valid`=1. On `imem_req_ready` go to `FETCH_WAIT`. `imem_rsp_valid` is ignored in this state.
- `FETCH_WAIT`: on `imem_rsp_valid`, latch `imem_rsp_data` into `inst_o` and go to `DECODE`.
- `DECODE` classifies `inst_o[6:0]`:
  - `ebreak` (32'h0010_0073): go to `HALT`, `illegal`=0.
  - Opcode not in {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, OP_IMM_32, OP_32, MISC_MEM}, or SYSTEM other than `ebreak`: go to `HALT`, `illegal`=1.
  - Otherwise go to `EXECUTE`.
- `EXECUTE`: LOAD/STORE go to `MEM_REQ`; everything else goes to `WRITEBACK`.
- `MEM_REQ`: `dmem_req_valid`=1. On `dmem_req_ready` go to `MEM_WAIT`.
- `MEM_WAIT`: on `dmem_rsp_valid` go to `WRITEBACK`.
- `WRITEBACK`:
  - `rf_wen`=1 for LUI, AUIPC, JAL, JALR, LOAD, OP*, and only when `inst_o[11:7]`≠0.
  - `pc_o` ← `next_pc_i`; `instret_cnt`+1; go to `FETCH_REQ`.
  - BRANCH, STORE and MISC_MEM (treated as no-op) do not write the register file.
- `HALT`: absorbing; all requests deasserted; `halt`=1; counters frozen. Leaves only on `rst`.
- `cycle_cnt` increments every non-halt cycle. Both counters wrap modulo 2^64.

## Timing
- Reset values:
  - state `FETCH_REQ`; `pc_o`=`RESET_PC`; `inst_o`=32'h0000_0013 (nop)
  - `rf_wen`=0; `halt`=0; `illegal`=0; both counters 0
  - `imem_req_valid`=1 in the first cycle after reset deasserts
- All outputs are registered or decoded from state only; no combinational path from any input to any output.
- An imem/dmem response arrives no earlier than the cycle after the request is accepted.
- Zero-wait-state memories (ready=1, rsp the following cycle):
  - non-memory instruction: 5 cycles, FETCH_REQ→WRITEBACK
  - load/store: 7 cycles
- Holding ready low stalls in the request state with the request held stable; valid never drops before acceptance.
- `rst` during any state, including a wait state, aborts immediately. Memories share `rst`, so no stale response is delivered afterwards.
- `rst` and an `imem_rsp_valid` in the same cycle: reset wins and the instruction is not latched.

## Structure
- Package `npc_pkg`:
  - opcode localparams (7-bit RV64I major opcodes)
  - `EBREAK` and `NOP` encodings
  - the state enum
- Sub-module `npc_inst_class`: combinational opcode → {legal, is_mem, writes_rd, is_ebreak}. It is shared with the future pipelined control.
- The FSM, PC, IF/ID register and counters are flat in `npc_ctrl`.

## Test plan
- Reset, then `addi x1,x0,5` (32'h0050_0093) from zero-wait memory → `imem_addr`=8000_0000, `rf_wen` pulses in cycle 5, `pc_o`=8000_0004, `instret_cnt`=1.
- `imem_req_ready` held low for 3 cycles, then `rsp_valid` after a 2-cycle delay → request held stable, `inst_o` latched only on `rsp_valid`, latency 5+3+1=9 cycles.
- `ld x2,0(x1)` with `dmem_req_ready` delayed 2 cycles → 9 cycles total, `rf_wen`=1; `sd` → `rf_wen` stays 0, `instret_cnt` increments.
- `addi x0,x0,1` and `beq` with `next_pc_i`=8000_0100 → `rf_wen`=0 for both; `pc_o`=8000_0100 after the branch.
- `ebreak` → `halt`=1, `illegal`=0, no further `imem_req_valid`; 32'hFFFF_FFFF → `halt`=1, `illegal`=1.
- `rst` asserted in `MEM_WAIT` → next cycle `pc_o`=8000_0000, state `FETCH_REQ`, counters 0, `dmem_req_valid`=0.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared encodings for the NPC control path: RV64I major opcodes, special instructions, FSM states.
// No logic; imported by the sequencer and the instruction classifier.
package npc_pkg;

    localparam logic [6:0] OP_LUI       = 7'b0110111;
    localparam logic [6:0] OP_AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP        = 7'b0110011;
    localparam logic [6:0] OP_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_OP_32     = 7'b0111011;
    localparam logic [6:0] OP_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef logic [2:0] state_t;
    localparam state_t S_FETCH_REQ  = 3'd0;
    localparam state_t S_FETCH_WAIT = 3'd1;
    localparam state_t S_DECODE     = 3'd2;
    localparam state_t S_EXECUTE    = 3'd3;
    localparam state_t S_MEM_REQ    = 3'd4;
    localparam state_t S_MEM_WAIT   = 3'd5;
    localparam state_t S_WRITEBACK  = 3'd6;
    localparam state_t S_HALT       = 3'd7;

endpackage

// File: rtl/npc_inst_class.sv
// Combinational opcode classifier: legal / memory access / writes rd / ebreak.
// Zero latency, no flow control; shared with the pipelined control.
module npc_inst_class
    import npc_pkg::*;
(
    input  logic [31:0] inst,
    output logic        legal,
    output logic        is_mem,
    output logic        writes_rd,
    output logic        is_ebreak
);

    logic [6:0] opcode;
    assign opcode = inst[6:0];

    // SYSTEM is only legal as the exact ebreak encoding, reported separately.
    always_comb begin
        legal     = 1'b0;
        is_mem    = 1'b0;
        writes_rd = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
            OP_OP_IMM, OP_OP, OP_OP_IMM_32, OP_OP_32: begin
                legal     = 1'b1;
                writes_rd = 1'b1;
            end
            OP_LOAD: begin
                legal     = 1'b1;
                is_mem    = 1'b1;
                writes_rd = 1'b1;
            end
            OP_STORE: begin
                legal  = 1'b1;
                is_mem = 1'b1;
            end
            OP_BRANCH, OP_MISC_MEM: legal = 1'b1;
            default: ;
        endcase
    end

    assign is_ebreak = (inst == EBREAK);

endmodule

// File: rtl/npc_ctrl.sv
// Multi-cycle RV64I sequencer: PC, IF/ID register, mem handshakes, rf write enable, halt, counters.
// 5 cycles per ALU op, 7 per load/store at zero wait; low ready stalls with the request held stable.
module npc_ctrl
    import npc_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    input  logic        dmem_rsp_valid,
    input  logic [63:0] next_pc_i,
    output logic [63:0] pc_o,
    output logic [31:0] inst_o,
    output logic        rf_wen,
    output logic        halt,
    output logic        illegal,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt
);

    state_t state, state_nxt;
    logic   legal, is_mem, writes_rd, is_ebreak;

    npc_inst_class u_inst_class (
        .inst      (inst_o),
        .legal     (legal),
        .is_mem    (is_mem),
        .writes_rd (writes_rd),
        .is_ebreak (is_ebreak)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH_REQ:  if (imem_req_ready) state_nxt = S_FETCH_WAIT;
            S_FETCH_WAIT: if (imem_rsp_valid) state_nxt = S_DECODE;
            S_DECODE:     state_nxt = (is_ebreak || !legal) ? S_HALT : S_EXECUTE;
            S_EXECUTE:    state_nxt = is_mem ? S_MEM_REQ : S_WRITEBACK;
            S_MEM_REQ:    if (dmem_req_ready) state_nxt = S_MEM_WAIT;
            S_MEM_WAIT:   if (dmem_rsp_valid) state_nxt = S_WRITEBACK;
            S_WRITEBACK:  state_nxt = S_FETCH_REQ;
            default:      state_nxt = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH_REQ;
            pc_o        <= RESET_PC;
            inst_o      <= NOP;
            illegal     <= 1'b0;
            cycle_cnt   <= 64'd0;
            instret_cnt <= 64'd0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH_WAIT && imem_rsp_valid)
                inst_o <= imem_rsp_data;
            if (state == S_DECODE && !is_ebreak && !legal)
                illegal <= 1'b1;
            if (state == S_WRITEBACK) begin
                pc_o        <= next_pc_i;
                instret_cnt <= instret_cnt + 64'd1;
            end
            if (state != S_HALT)
                cycle_cnt <= cycle_cnt + 64'd1;
        end
    end

    // Outputs depend only on state and registered instruction, never on inputs.
    assign imem_req_valid = (state == S_FETCH_REQ);
    assign imem_addr      = pc_o;
    assign dmem_req_valid = (state == S_MEM_REQ);
    assign rf_wen         = (state == S_WRITEBACK) && writes_rd && (inst_o[11:7] != 5'd0);
    assign halt           = (state == S_HALT);

endmodule
